// File: rtl/efpga_top_cfg_pkg.sv
// Shared constants for the eFPGA pad wrapper and its serial configuration front-end.
// Pad indices describe the fixed 38-pin bus layout.
package efpga_top_cfg_pkg;

  localparam logic [31:0] CTRL_WORD_DEF = 32'h0000FAB1;

  localparam int PAD_W       = 38;
  localparam int PAD_CLK     = 0;
  localparam int PAD_SCLK    = 3;
  localparam int PAD_SDATA   = 4;
  localparam int PAD_RX      = 5;
  localparam int PAD_LED     = 6;
  localparam int PAD_USER_LO = 7;
  localparam int USER_W      = 31;

  localparam int CFG_W = 32;
  localparam int CNT_W = 12;

  // Synchronizer-stage state for one serial pin
  typedef struct packed {
    logic meta;
    logic sync;
  } sync2_t;

  function automatic sync2_t sync2_step(sync2_t cur, logic pin);
    sync2_t nxt;
    nxt.meta = pin;
    nxt.sync = cur.meta;
    return nxt;
  endfunction

endpackage

// File: rtl/efpga_top_cfg_if.sv
// Configuration word bus from the serial receiver to the fabric frame writer.
// master drives committed words; slave consumes them.
interface efpga_top_cfg_if;
  import efpga_top_cfg_pkg::*;

  logic [CFG_W-1:0] cfg_word;
  logic             cfg_word_valid;
  logic [CNT_W-1:0] cfg_word_count;

  modport master (
    output cfg_word,
    output cfg_word_valid,
    output cfg_word_count
  );

  modport slave (
    input cfg_word,
    input cfg_word_valid,
    input cfg_word_count
  );

endinterface

// File: rtl/efpga_top_cfg_cfg_bitbang_rx.sv
// Bit-banged serial config receiver: data bits on rising s_clk, control bits on falling s_clk.
// A word commits when the control window matches CTRL_WORD; pin edges act two CLK edges later.
module cfg_bitbang_rx
  import efpga_top_cfg_pkg::*;
#(
  parameter logic [CFG_W-1:0] CTRL_WORD = CTRL_WORD_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_clk_i,
  input  logic             s_data_i,
  output logic [CFG_W-1:0] cfg_word_o,
  output logic             cfg_word_valid_o,
  output logic [CNT_W-1:0] cfg_word_count_o,
  output logic             sclk_edge_o
);

  sync2_t           sclk_q, sclk_d;
  sync2_t           sdata_q, sdata_d;
  logic             sclk_prev_q;
  logic [CFG_W-1:0] data_sr_q, data_sr_d;
  logic [CFG_W-1:0] ctrl_sr_q, ctrl_sr_d;
  logic [CFG_W-1:0] ctrl_next;
  logic [CFG_W-1:0] cfg_word_q, cfg_word_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sclk_rise, sclk_fall;

  assign sclk_d = sync2_step(sclk_q, s_clk_i);
  assign sdata_d = sync2_step(sdata_q, s_data_i);

  assign sclk_rise = sclk_q.sync & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q.sync & sclk_prev_q;
  assign ctrl_next = {ctrl_sr_q[CFG_W-2:0], sdata_q.sync};

  always_comb begin
    data_sr_d  = data_sr_q;
    ctrl_sr_d  = ctrl_sr_q;
    cfg_word_d = cfg_word_q;
    valid_d    = 1'b0;
    count_d    = count_q;
    if (sclk_rise) begin
      data_sr_d = {data_sr_q[CFG_W-2:0], sdata_q.sync};
    end
    if (sclk_fall) begin
      // Clearing the control window on a match forces a fresh 32-pair sequence per word
      if (ctrl_next == CTRL_WORD) begin
        cfg_word_d = data_sr_q;
        valid_d    = 1'b1;
        count_d    = count_q + CNT_W'(1);
        ctrl_sr_d  = '0;
      end else begin
        ctrl_sr_d = ctrl_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q      <= '0;
      sdata_q     <= '0;
      sclk_prev_q <= 1'b0;
      data_sr_q   <= '0;
      ctrl_sr_q   <= '0;
      cfg_word_q  <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      sclk_prev_q <= sclk_q.sync;
      data_sr_q   <= data_sr_d;
      ctrl_sr_q   <= ctrl_sr_d;
      cfg_word_q  <= cfg_word_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
    end
  end

  assign cfg_word_o       = cfg_word_q;
  assign cfg_word_valid_o = valid_q;
  assign cfg_word_count_o = count_q;
  assign sclk_edge_o      = sclk_rise | sclk_fall;

endmodule

// File: rtl/efpga_top_cfg.sv
// eFPGA top wrapper: combinational pad <-> fabric user I/O mapping, serial config receiver
// and the ReceiveLED activity timer (reloaded on every synchronized s_clk edge).
module efpga_top_cfg
  import efpga_top_cfg_pkg::*;
#(
  parameter logic [CFG_W-1:0] CTRL_WORD = CTRL_WORD_DEF,
  parameter int               LED_HOLD  = 16
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic [PAD_W-1:0]  io_in,
  output logic [PAD_W-1:0]  io_out,
  output logic [PAD_W-1:0]  io_oeb,
  output logic [USER_W-1:0] fab_O,
  input  logic [USER_W-1:0] fab_I,
  input  logic [USER_W-1:0] fab_T,
  efpga_top_cfg_if.master   cfg
);

  logic                timer_q, timer_nz;
  logic [LED_HOLD-1:0] led_timer_q, led_timer_d;
  logic                sclk_edge;
  logic                unused_pads;

  // CLK arrives on its own port; clk_sel and Rx are reserved
  assign unused_pads = ^{io_in[PAD_CLK], io_in[2:1], io_in[PAD_RX], io_in[PAD_LED]};

  cfg_bitbang_rx #(
    .CTRL_WORD (CTRL_WORD)
  ) u_rx (
    .clk_i            (CLK),
    .rst_ni           (resetn),
    .s_clk_i          (io_in[PAD_SCLK]),
    .s_data_i         (io_in[PAD_SDATA]),
    .cfg_word_o       (cfg.cfg_word),
    .cfg_word_valid_o (cfg.cfg_word_valid),
    .cfg_word_count_o (cfg.cfg_word_count),
    .sclk_edge_o      (sclk_edge)
  );

  assign timer_nz = (led_timer_q != '0);

  always_comb begin
    led_timer_d = led_timer_q;
    if (sclk_edge) begin
      led_timer_d = '1;
    end else if (timer_nz) begin
      led_timer_d = led_timer_q - LED_HOLD'(1);
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      led_timer_q <= '0;
    end else begin
      led_timer_q <= led_timer_d;
    end
  end

  assign timer_q = timer_nz;

  assign fab_O  = io_in[PAD_USER_LO +: USER_W];
  assign io_out = {fab_I, timer_q, 6'b00_0000};
  assign io_oeb = {fab_T, 1'b0, 6'b11_1111};

endmodule

// File: tb/tb_efpga_top_cfg.sv
// Directed bench for efpga_top_cfg: pad-mapping vector table plus serial word sequences.
module tb_efpga_top_cfg;

  logic        clk = 1'b0;
  logic        resetn;
  logic [30:0] user_in;
  logic        s_clk, s_data;
  logic [37:0] io_in, io_out, io_oeb;
  logic [30:0] fab_O, fab_I, fab_T;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] got_q[$];

  efpga_top_cfg_if cfg_if ();

  assign io_in = {user_in, 1'b0, 1'b0, s_data, s_clk, 2'b00, clk};

  efpga_top_cfg dut (
    .CLK    (clk),
    .resetn (resetn),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb),
    .fab_O  (fab_O),
    .fab_I  (fab_I),
    .fab_T  (fab_T),
    .cfg    (cfg_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && cfg_if.cfg_word_valid) got_q.push_back(cfg_if.cfg_word);
  end

  typedef struct {
    logic [30:0] user;
    logic [30:0] fi;
    logic [30:0] ft;
    logic [30:0] exp_o;
    logic [30:0] exp_out;
    logic [30:0] exp_oeb;
  } io_vec_t;

  io_vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(3);
    resetn = 1'b1;
    step(2);
  endtask

  // One pair = 5 CLK cycles: s_clk high 2, low 3
  task automatic send_word(input logic [31:0] d, input logic [31:0] c, input int npairs);
    for (int i = 31; i > 31 - npairs; i--) begin
      s_data = d[i];
      s_clk  = 1'b0;
      step(1);
      s_clk = 1'b1;
      step(1);
      s_data = c[i];
      step(1);
      s_clk = 1'b0;
      step(2);
    end
  endtask

  logic [31:0] words[4];
  int          n;

  initial begin
    vecs[0] = '{31'h2AAAAAAA, 31'h55555555, 31'h7FFF0000, 31'h2AAAAAAA, 31'h55555555, 31'h7FFF0000};
    vecs[1] = '{31'h00000000, 31'h00000000, 31'h00000000, 31'h00000000, 31'h00000000, 31'h00000000};
    vecs[2] = '{31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF};
    vecs[3] = '{31'h12345678, 31'h0ABCDEF0, 31'h00000001, 31'h12345678, 31'h0ABCDEF0, 31'h00000001};
    words[0] = 32'h00000001;
    words[1] = 32'h80000000;
    words[2] = 32'hFFFFFFFF;
    words[3] = 32'h12345678;

    resetn  = 1'b0;
    user_in = '0;
    s_clk   = 1'b0;
    s_data  = 1'b0;
    fab_I   = '0;
    fab_T   = '0;
    step(3);
    chk("rst_cfg_word", cfg_if.cfg_word, 32'h0);
    chk("rst_valid", cfg_if.cfg_word_valid, 1'b0);
    chk("rst_count", cfg_if.cfg_word_count, 12'h0);
    chk("rst_io_out_low", io_out[6:0], 7'h00);
    chk("rst_io_oeb_low", io_oeb[6:0], 7'h3F);
    resetn = 1'b1;
    step(2);

    for (int i = 0; i < 4; i++) begin
      user_in = vecs[i].user;
      fab_I   = vecs[i].fi;
      fab_T   = vecs[i].ft;
      #1;
      chk("io_fab_O", fab_O, vecs[i].exp_o);
      chk("io_out_user", io_out[37:7], vecs[i].exp_out);
      chk("io_oeb_user", io_oeb[37:7], vecs[i].exp_oeb);
      chk("io_out_low", io_out[6:0], 7'h00);
      chk("io_oeb_low", io_oeb[6:0], 7'h3F);
      step(1);
    end

    got_q.delete();
    send_word(32'hDEADBEEF, 32'h0000FAB1, 32);
    step(8);
    chk("w1_pulses", got_q.size(), 1);
    if (got_q.size() > 0) chk("w1_word", got_q[0], 32'hDEADBEEF);
    chk("w1_cfg_word", cfg_if.cfg_word, 32'hDEADBEEF);
    chk("w1_count", cfg_if.cfg_word_count, 12'd1);
    chk("w1_led", io_out[6], 1'b1);

    do_reset();
    got_q.delete();
    send_word(32'hDEADBEEF, 32'h0000FAB0, 32);
    step(8);
    chk("bad_pulses", got_q.size(), 0);
    chk("bad_count", cfg_if.cfg_word_count, 12'd0);
    chk("bad_cfg_word", cfg_if.cfg_word, 32'h0);

    got_q.delete();
    for (int w = 0; w < 4; w++) send_word(words[w], 32'h0000FAB1, 32);
    step(8);
    chk("b2b_pulses", got_q.size(), 4);
    for (int w = 0; w < 4; w++) begin
      if (w < got_q.size()) chk("b2b_word", got_q[w], words[w]);
    end
    chk("b2b_count", cfg_if.cfg_word_count, 12'd4);

    got_q.delete();
    send_word(32'hFFFF0000, 32'h0000FAB1, 16);
    do_reset();
    send_word(32'hA5A5A5A5, 32'h0000FAB1, 32);
    step(8);
    chk("midrst_pulses", got_q.size(), 1);
    if (got_q.size() > 0) chk("midrst_word", got_q[0], 32'hA5A5A5A5);
    chk("midrst_count", cfg_if.cfg_word_count, 12'd1);

    // Final falling s_clk, then count CLK edges until the LED drops
    s_clk = 1'b1;
    step(3);
    s_clk = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (io_out[6] && n < 70000);
    chk("led_hold_edges", n, 65538);
    step(5);
    chk("led_idle_off", io_out[6], 1'b0);
    chk("led_no_commit", got_q.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/efpga_top_cfg.md
# efpga_top_cfg

Top-level I/O wrapper and configuration front-end of the eFPGA. It maps the 38-bit pad bus onto the fabric user I/O and decodes the bit-banged serial configuration port (s_clk/s_data) into 32-bit configuration words for the fabric's frame writer. The fabric array itself is a separate block; this wrapper only carries its user I/O.

## Interface
Parameters:
- CTRL_WORD, 32'h0000FAB1: control pattern that commits a configuration word
- LED_HOLD, 16: width of the ReceiveLED activity timer

Ports:
- CLK  in  1  system clock (same net as io_in[0])
- resetn  in  1  asynchronous, active-low reset
- io_in  in  38  pads: [0] CLK, [2:1] clk_sel (must be 2'b00, ignored), [3] s_clk, [4] s_data, [5] Rx (reserved, ignored), [37:7] user inputs
- io_out  out  38  pads: [5:0]=0, [6] ReceiveLED, [37:7] fabric outputs
- io_oeb  out  38  pad output-enable-bar: [5:0]=1, [6]=0, [37:7]=fab_T
- fab_O  out  31  io_in[37:7] to fabric, combinational
- fab_I  in  31  fabric outputs, driven to io_out[37:7]
- fab_T  in  31  fabric tristate control, driven unmodified to io_oeb[37:7]
- cfg_word  out  32  last committed configuration word
- cfg_word_valid  out  1  one-cycle strobe per committed word
- cfg_word_count  out  12  committed words since reset, wraps at 4096

## Operation
- I/O mapping is purely combinational; no inversion anywhere.
- s_clk and s_data each pass through the same two-flop synchronizer; a third flop holds the previous synchronized s_clk.
- Rising edge of synchronized s_clk: data_sr <= {data_sr[30:0], s_data_sync}.
- Falling edge: ctrl_sr_next = {ctrl_sr[30:0], s_data_sync}. If ctrl_sr_next == CTRL_WORD: cfg_word <= data_sr, cfg_word_valid <= 1, cfg_word_count increments, ctrl_sr <= 0. Otherwise ctrl_sr <= ctrl_sr_next.
- Clearing ctrl_sr forces each word to be a complete 32-pair sequence: data bit MSB first, clocked by rising s_clk, then control bit (CTRL_WORD MSB first), clocked by falling s_clk.
- Words whose control stream does not match are silently dropped; data_sr keeps shifting (sliding window, no error flag).
- ReceiveLED: timer reloads to all-ones on every synchronized s_clk edge and decrements to 0; LED = (timer != 0).

## Timing
- Reset: all synchronizers, data_sr, ctrl_sr, cfg_word, cfg_word_count, and the timer reset to 0. cfg_word_valid=0, ReceiveLED=0.
- A pin edge on s_clk before CLK edge k is acted on at CLK edge k+2. cfg_word_valid is high for exactly the cycle following k+2.
- Minimum s_clk high and low time: 2 CLK cycles each. s_data must be stable from 1 cycle before each s_clk edge until 1 cycle after it. Faster toggling is unsupported.
- Reset mid-word discards the partial word; the next word starts fresh.
- Count wraps from 4095 to 0 without any flag.

## Structure
- Shared package: CTRL_WORD default, pad index constants (PAD_CLK=0, PAD_SCLK=3, PAD_SDATA=4, PAD_RX=5, PAD_LED=6, PAD_USER_LO=7, USER_W=31).
- One sub-module, cfg_bitbang_rx: synchronizers, edge detect, both shift registers, commit logic and counter. The wrapper holds the pad mapping and the LED timer.

## Test plan
- Reset, then 32 pairs with data 32'hDEADBEEF and ctrl 32'h0000FAB1 (s_clk 2 high / 3 low cycles) -> single valid pulse, cfg_word=DEADBEEF, count=1.
- Same sequence with ctrl 32'h0000FAB0 -> no valid pulse, count stays 0.
- 4 back-to-back words 0x00000001, 0x80000000, 0xFFFFFFFF, 0x12345678 -> 4 pulses in order, count=4.
- Reset asserted after 16 pairs, then one full word 0xA5A5A5A5 -> exactly one pulse with A5A5A5A5.
- Drive io_in[37:7]=31'h2AAAAAAA with fab_I=31'h55555555 and fab_T=31'h7FFF0000 -> fab_O=2AAAAAAA, io_out[37:7]=55555555, io_oeb[37:7]=7FFF0000, io_oeb[5:0]=6'h3F.
- Idle after traffic -> ReceiveLED stays high for 2^16-1 cycles after the last s_clk edge, then goes low.
